// File: rtl/qspi_psram_mchan_model_if.sv
// Shared QSPI bus between the host controller and the multi-device PSRAM model.
interface qspi_psram_mchan_model_if #(
    parameter int CE_NUM = 3
);
    logic              sck;
    logic [CE_NUM-1:0] ce_n;
    logic [3:0]        sio_i;
    logic [3:0]        sio_o;
    logic              sio_oe;
    logic [CE_NUM-1:0] qpi_mode;
    logic              multi_err;

    modport master (output sck, ce_n, sio_i, input sio_o, sio_oe, qpi_mode, multi_err);
    modport slave  (input sck, ce_n, sio_i, output sio_o, sio_oe, qpi_mode, multi_err);
endinterface

// File: rtl/qspi_psram_mchan_model.sv
// Multi chip-select QSPI PSRAM behavioural model: CE_NUM byte memories behind one
// shared SCK/SIO bus, SPI and QPI command modes, quad read with wait, page wrap.
module qspi_psram_mchan_model #(
    parameter int CE_NUM   = 3,
    parameter int ADR_W    = 12,
    parameter int PAGE_W   = 10,
    parameter int WAIT_CYC = 6
) (
    input logic                     clk,
    input logic                     rst,
    qspi_psram_mchan_model_if.slave bus
);
    localparam int               MEM_DEPTH = CE_NUM << ADR_W;
    localparam logic [ADR_W-1:0] PAGE_MASK = {ADR_W{1'b1}} >> (ADR_W - PAGE_W);
    localparam logic [4:0]       WAIT_LAST = 5'(WAIT_CYC - 1);
    localparam logic [4:0]       WAIT_SAT  = 5'(WAIT_CYC);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADR    = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RDATA  = 3'd4,
        ST_WDATA  = 3'd5,
        ST_IGNORE = 3'd6
    } state_t;

    // Next address inside the current page: low PAGE_W bits wrap, upper bits kept.
    function automatic logic [ADR_W-1:0] page_inc(input logic [ADR_W-1:0] a);
        return (a & ~PAGE_MASK) | ((a + {{(ADR_W-1){1'b0}}, 1'b1}) & PAGE_MASK);
    endfunction

    state_t            state_r;
    logic              sck_q_r;
    logic [1:0]        cur_sel_r;
    logic [7:0]        cmd_sh_r;
    logic [2:0]        bit_cnt_r;
    logic [4:0]        ph_cnt_r;
    logic [ADR_W-1:0]  adr_r;
    logic [7:0]        wr_sh_r;
    logic              quad_r;
    logic              rd_r;
    logic              arm_pend_r;
    logic              arm_cur_r;
    logic [3:0]        sio_o_r;
    logic              sio_oe_r;
    logic [CE_NUM-1:0] qpi_r;
    logic              multi_err_r;
    logic [7:0]        mem [MEM_DEPTH];

    logic              rise_s;
    logic              fall_s;
    logic [1:0]        low_cnt_s;
    logic [1:0]        sel_s;
    logic              single_s;
    logic              multi_s;
    logic              sel_ok_s;
    logic              qpi_idle_s;
    logic              qpi_cur_s;
    logic [7:0]        cmd_nxt_s;
    logic [7:0]        wr_nxt_s;
    logic [ADR_W-1:0]  adr_nxt_s;
    logic              cmd_last_s;
    logic              adr_last_s;
    logic              wr_last_s;
    logic [ADR_W+1:0]  mem_idx_s;
    logic [7:0]        rd_byte_s;
    logic              mem_we_s;

    // Bus decode: SCK edges, single-device select, next shift values and memory port.
    always_comb begin
        rise_s    = bus.sck & ~sck_q_r;
        fall_s    = ~bus.sck & sck_q_r;
        low_cnt_s = 2'd0;
        sel_s     = 2'd0;
        for (int i = 0; i < CE_NUM; i++) begin
            low_cnt_s = low_cnt_s + {1'b0, ~bus.ce_n[i]};
            sel_s     = bus.ce_n[i] ? sel_s : 2'(i);
        end
        single_s   = (low_cnt_s == 2'd1);
        multi_s    = (low_cnt_s >= 2'd2);
        sel_ok_s   = single_s && (sel_s == cur_sel_r);
        qpi_idle_s = qpi_r[sel_s];
        qpi_cur_s  = qpi_r[cur_sel_r];
        cmd_nxt_s  = qpi_cur_s ? ((cmd_sh_r << 4) | {4'h0, bus.sio_i})
                               : ((cmd_sh_r << 1) | {7'h00, bus.sio_i[0]});
        wr_nxt_s   = quad_r ? ((wr_sh_r << 4) | {4'h0, bus.sio_i})
                            : ((wr_sh_r << 1) | {7'h00, bus.sio_i[0]});
        adr_nxt_s  = quad_r ? ((adr_r << 4) | ADR_W'(bus.sio_i))
                            : ((adr_r << 1) | ADR_W'(bus.sio_i[0]));
        cmd_last_s = qpi_cur_s ? (bit_cnt_r == 3'd1) : (bit_cnt_r == 3'd7);
        adr_last_s = quad_r ? (ph_cnt_r == 5'd5) : (ph_cnt_r == 5'd23);
        wr_last_s  = quad_r ? (bit_cnt_r == 3'd1) : (bit_cnt_r == 3'd7);
        mem_idx_s  = {cur_sel_r, adr_r};
        rd_byte_s  = mem[mem_idx_s];
        mem_we_s   = (state_r == ST_WDATA) && rise_s && sel_ok_s && wr_last_s;
    end

    // Protocol FSM with registered bus outputs, mode flags and reset-enable arming.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            sck_q_r     <= 1'b0;
            cur_sel_r   <= 2'd0;
            cmd_sh_r    <= 8'h00;
            bit_cnt_r   <= 3'd0;
            ph_cnt_r    <= 5'd0;
            adr_r       <= '0;
            wr_sh_r     <= 8'h00;
            quad_r      <= 1'b0;
            rd_r        <= 1'b0;
            arm_pend_r  <= 1'b0;
            arm_cur_r   <= 1'b0;
            sio_o_r     <= 4'h0;
            sio_oe_r    <= 1'b0;
            qpi_r       <= '0;
            multi_err_r <= 1'b0;
        end else begin
            sck_q_r <= bus.sck;
            if (multi_s) begin
                multi_err_r <= 1'b1;
            end
            if (state_r != ST_IDLE && !sel_ok_s) begin
                // Chip select ended (or went ambiguous): abort, hand 0x66 arming to next cycle.
                state_r    <= ST_IDLE;
                sio_oe_r   <= 1'b0;
                sio_o_r    <= 4'h0;
                bit_cnt_r  <= 3'd0;
                ph_cnt_r   <= 5'd0;
                arm_cur_r  <= arm_pend_r;
                arm_pend_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (rise_s && single_s) begin
                            cur_sel_r <= sel_s;
                            cmd_sh_r  <= qpi_idle_s ? {4'h0, bus.sio_i} : {7'h00, bus.sio_i[0]};
                            bit_cnt_r <= 3'd1;
                            state_r   <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        if (rise_s) begin
                            cmd_sh_r  <= cmd_nxt_s;
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (cmd_last_s) begin
                                bit_cnt_r <= 3'd0;
                                ph_cnt_r  <= 5'd0;
                                adr_r     <= '0;
                                state_r   <= ST_IGNORE;
                                case (cmd_nxt_s)
                                    8'h03: if (!qpi_cur_s) begin
                                        state_r <= ST_ADR; quad_r <= 1'b0; rd_r <= 1'b1;
                                    end
                                    8'h02: if (!qpi_cur_s) begin
                                        state_r <= ST_ADR; quad_r <= 1'b0; rd_r <= 1'b0;
                                    end
                                    8'hEB: begin
                                        state_r <= ST_ADR; quad_r <= 1'b1; rd_r <= 1'b1;
                                    end
                                    8'h38: begin
                                        state_r <= ST_ADR; quad_r <= 1'b1; rd_r <= 1'b0;
                                    end
                                    8'h35: if (!qpi_cur_s) qpi_r[cur_sel_r] <= 1'b1;
                                    8'hF5: if (qpi_cur_s) qpi_r[cur_sel_r] <= 1'b0;
                                    8'h66: arm_pend_r <= 1'b1;
                                    8'h99: if (arm_cur_r) qpi_r[cur_sel_r] <= 1'b0;
                                    default: state_r <= ST_IGNORE;
                                endcase
                            end
                        end
                    end
                    ST_ADR: begin
                        if (rise_s) begin
                            adr_r    <= adr_nxt_s;
                            ph_cnt_r <= ph_cnt_r + 5'd1;
                            if (adr_last_s) begin
                                ph_cnt_r  <= 5'd0;
                                bit_cnt_r <= 3'd0;
                                if (!rd_r) begin
                                    state_r <= ST_WDATA;
                                end else if (quad_r && WAIT_CYC > 0) begin
                                    state_r <= ST_WAIT;
                                end else begin
                                    state_r <= ST_RDATA;
                                end
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (rise_s) begin
                            if (ph_cnt_r == WAIT_LAST) begin
                                ph_cnt_r <= WAIT_SAT;
                                state_r  <= ST_RDATA;
                            end else begin
                                ph_cnt_r <= ph_cnt_r + 5'd1;
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (fall_s) begin
                            sio_oe_r  <= 1'b1;
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (quad_r) begin
                                sio_o_r <= bit_cnt_r[0] ? rd_byte_s[3:0] : rd_byte_s[7:4];
                                if (bit_cnt_r[0]) begin
                                    bit_cnt_r <= 3'd0;
                                    adr_r     <= page_inc(adr_r);
                                end
                            end else begin
                                sio_o_r <= {2'b00, rd_byte_s[3'd7 - bit_cnt_r], 1'b0};
                                if (bit_cnt_r == 3'd7) begin
                                    adr_r <= page_inc(adr_r);
                                end
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (rise_s) begin
                            wr_sh_r   <= wr_nxt_s;
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (wr_last_s) begin
                                bit_cnt_r <= 3'd0;
                                adr_r     <= page_inc(adr_r);
                            end
                        end
                    end
                    ST_IGNORE: begin
                        state_r <= ST_IGNORE;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Byte storage for all devices; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[mem_idx_s] <= wr_nxt_s;
        end
    end

    assign bus.sio_o     = sio_o_r;
    assign bus.sio_oe    = sio_oe_r;
    assign bus.qpi_mode  = qpi_r;
    assign bus.multi_err = multi_err_r;
endmodule

// File: tb/tb_qspi_psram_mchan_model.sv
// Self-checking bench: directed scenarios plus randomized bursts compared against
// a per-device byte-array reference model.
`timescale 1ns/1ps
module tb_qspi_psram_mchan_model;
    localparam int CE_NUM   = 3;
    localparam int ADR_W    = 12;
    localparam int PAGE_W   = 10;
    localparam int WAIT_CYC = 6;
    localparam int AMASK    = (1 << ADR_W) - 1;
    localparam int PMASK    = (1 << PAGE_W) - 1;

    logic clk = 1'b0;
    logic rst;

    qspi_psram_mchan_model_if #(.CE_NUM(CE_NUM)) bus ();

    qspi_psram_mchan_model #(
        .CE_NUM(CE_NUM), .ADR_W(ADR_W), .PAGE_W(PAGE_W), .WAIT_CYC(WAIT_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0]        ref_mem [CE_NUM][1 << ADR_W];
    logic [CE_NUM-1:0] ref_qpi;
    bit                ref_armed;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int page_next(input int a);
        return (a & AMASK & ~PMASK) | ((a + 1) & PMASK);
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sck_cycle(input logic [3:0] d, output logic [3:0] o, output logic oe);
        bus.sio_i = d;
        wait_clk(1);
        bus.sck = 1'b1;
        wait_clk(3);
        bus.sck = 1'b0;
        wait_clk(3);
        o  = bus.sio_o;
        oe = bus.sio_oe;
    endtask

    task automatic send_units(input logic [31:0] v, input int n, input bit q,
                              output logic [3:0] o, output logic oe);
        for (int u = n - 1; u >= 0; u--) begin
            sck_cycle(q ? v[4*u +: 4] : {3'b000, v[u]}, o, oe);
        end
    endtask

    task automatic ce_begin(input int dev);
        bus.ce_n = ~(CE_NUM'(1) << dev);
        wait_clk(2);
    endtask

    task automatic ce_finish(input bit was_66);
        bus.ce_n = '1;
        wait_clk(3);
        ref_armed = was_66;
    endtask

    task automatic send_cmd(input int dev, input logic [7:0] op);
        logic [3:0] o;
        logic       oe;
        send_units({24'h0, op}, ref_qpi[dev] ? 2 : 8, ref_qpi[dev], o, oe);
    endtask

    task automatic host_cmd(input int dev, input logic [7:0] op);
        ce_begin(dev);
        send_cmd(dev, op);
        case (op)
            8'h35:   if (!ref_qpi[dev]) ref_qpi[dev] = 1'b1;
            8'hF5:   if (ref_qpi[dev]) ref_qpi[dev] = 1'b0;
            8'h99:   if (ref_armed) ref_qpi[dev] = 1'b0;
            default: ;
        endcase
        ce_finish(op == 8'h66);
    endtask

    // bytes[7:0] is the first byte on the bus
    task automatic host_write(input int dev, input logic [7:0] op, input logic [23:0] adr,
                              input logic [31:0] bytes, input int n);
        logic [3:0] o;
        logic       oe;
        bit         q;
        int         a;
        q = (op == 8'h38);
        ce_begin(dev);
        send_cmd(dev, op);
        send_units({8'h0, adr}, q ? 6 : 24, q, o, oe);
        a = adr & AMASK;
        for (int i = 0; i < n; i++) begin
            send_units({24'h0, bytes[8*i +: 8]}, q ? 2 : 8, q, o, oe);
            ref_mem[dev][a] = bytes[8*i +: 8];
            a = page_next(a);
        end
        ce_finish(1'b0);
    endtask

    task automatic host_read(input int dev, input logic [7:0] op, input logic [23:0] adr,
                             input int n, input string tag, input bit rst_mid);
        logic [3:0] o;
        logic       oe;
        logic [7:0] got;
        logic [3:0] junk;
        bit         q;
        int         a;
        int         upb;
        int         pre;
        q   = (op == 8'hEB);
        upb = q ? 2 : 8;
        pre = q ? 6 + WAIT_CYC : 24;
        ce_begin(dev);
        send_cmd(dev, op);
        for (int k = 0; k < pre; k++) begin
            if (q) sck_cycle((k < 6) ? adr[4*(5-k) +: 4] : 4'h0, o, oe);
            else   sck_cycle({3'b000, adr[23-k]}, o, oe);
            if (k == pre - 2) check_eq({tag, "_oe_pre"}, {31'h0, oe}, 32'h0);
        end
        a = adr & AMASK;
        for (int b = 0; b < n; b++) begin
            got  = 8'h00;
            junk = 4'h0;
            for (int u = 0; u < upb; u++) begin
                if (b != 0 || u != 0) sck_cycle(4'h0, o, oe);
                got  = q ? {got[3:0], o} : {got[6:0], o[1]};
                junk = junk | (o & 4'b1101);
                if (u == 0) check_eq({tag, "_oe"}, {31'h0, oe}, 32'h1);
                if (rst_mid) begin
                    @(negedge clk);
                    rst = 1'b1;
                    #1;
                    check_eq({tag, "_rst_oe"}, {31'h0, bus.sio_oe}, 32'h0);
                    check_eq({tag, "_rst_qpi"}, {29'h0, bus.qpi_mode}, 32'h0);
                    check_eq({tag, "_rst_merr"}, {31'h0, bus.multi_err}, 32'h0);
                    wait_clk(2);
                    bus.ce_n = '1;
                    wait_clk(1);
                    rst       = 1'b0;
                    ref_qpi   = '0;
                    ref_armed = 1'b0;
                    wait_clk(2);
                    return;
                end
            end
            check_eq($sformatf("%s_b%0d", tag, b), {24'h0, got}, {24'h0, ref_mem[dev][a]});
            if (!q) check_eq({tag, "_spi_idle_lines"}, {28'h0, junk}, 32'h0);
            a = page_next(a);
        end
        ce_finish(1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0]  o;
        logic        oe;
        int          dev;
        int          n;
        logic [23:0] adr;
        logic [31:0] data;
        logic [7:0]  wop;
        logic [7:0]  rop;

        rst       = 1'b1;
        bus.sck   = 1'b0;
        bus.ce_n  = '1;
        bus.sio_i = 4'h0;
        ref_qpi   = '0;
        ref_armed = 1'b0;
        wait_clk(3);
        check_eq("rst_oe", {31'h0, bus.sio_oe}, 32'h0);
        check_eq("rst_sio_o", {28'h0, bus.sio_o}, 32'h0);
        check_eq("rst_qpi", {29'h0, bus.qpi_mode}, 32'h0);
        check_eq("rst_merr", {31'h0, bus.multi_err}, 32'h0);
        rst = 1'b0;
        wait_clk(2);

        // 1: SPI write/read on ce0
        host_write(0, 8'h02, 24'h000010, 32'h0000_3CA5, 2);
        host_read(0, 8'h03, 24'h000010, 2, "spi_rd", 1'b0);

        // 2: QPI on ce1, quad write across page end, quad read with wait
        host_cmd(1, 8'h35);
        check_eq("qpi_enter", {29'h0, bus.qpi_mode}, 32'h2);
        host_write(1, 8'h38, 24'h000000, 32'h0000_00EE, 1);
        host_write(1, 8'h38, 24'h000400, 32'h0000_0099, 1);
        host_write(1, 8'h38, 24'h0003FF, 32'h0000_2211, 2);
        host_read(1, 8'hEB, 24'h0003FF, 2, "qrd_wrap", 1'b0);
        host_read(1, 8'hEB, 24'h000000, 1, "qrd_pg0", 1'b0);
        host_read(1, 8'hEB, 24'h000400, 1, "qrd_pg1", 1'b0);
        ce_begin(1);
        send_cmd(1, 8'h03);
        send_units(32'h0, 30, 1'b1, o, oe);
        check_eq("qpi_03_ignored_oe", {31'h0, oe}, 32'h0);
        ce_finish(1'b0);

        // 3: device independence
        host_write(0, 8'h02, 24'h000020, 32'h0000_0077, 1);
        host_write(2, 8'h02, 24'h000020, 32'h0000_0088, 1);
        host_read(0, 8'h03, 24'h000020, 1, "indep_ce0", 1'b0);
        host_read(2, 8'hEB, 24'h000020, 1, "indep_ce2", 1'b0);

        // 4: abort after one nibble leaves the byte untouched
        host_write(0, 8'h02, 24'h000030, 32'h0000_0055, 1);
        ce_begin(0);
        send_cmd(0, 8'h38);
        send_units(32'h0000_0030, 6, 1'b1, o, oe);
        sck_cycle(4'hA, o, oe);
        ce_finish(1'b0);
        check_eq("abort_oe", {31'h0, bus.sio_oe}, 32'h0);
        host_read(0, 8'h03, 24'h000030, 1, "abort_rd", 1'b0);

        // 5: multiple chip selects, then reset-enable/reset sequencing
        bus.ce_n = 3'b100;
        wait_clk(2);
        send_units(32'h0000_00EB, 8, 1'b0, o, oe);
        send_units(32'h0, 8, 1'b1, o, oe);
        check_eq("multi_oe", {31'h0, oe}, 32'h0);
        check_eq("multi_err_set", {31'h0, bus.multi_err}, 32'h1);
        bus.ce_n = '1;
        wait_clk(3);
        check_eq("multi_err_sticky", {31'h0, bus.multi_err}, 32'h1);
        host_cmd(1, 8'h99);
        check_eq("rst99_unarmed", {29'h0, bus.qpi_mode}, {29'h0, ref_qpi});
        host_cmd(1, 8'h66);
        host_cmd(1, 8'h99);
        check_eq("rst66_99", {29'h0, bus.qpi_mode}, {29'h0, ref_qpi});
        host_cmd(2, 8'h35);
        host_cmd(2, 8'h66);
        host_cmd(2, 8'h05);
        host_cmd(2, 8'h99);
        check_eq("arm_expired", {29'h0, bus.qpi_mode}, {29'h0, ref_qpi});
        host_cmd(2, 8'hF5);
        check_eq("qpi_exit", {29'h0, bus.qpi_mode}, {29'h0, ref_qpi});

        // randomized bursts against the reference model
        for (int it = 0; it < 24; it++) begin
            dev = $urandom_range(0, CE_NUM - 1);
            if ($urandom_range(0, 3) == 0) host_cmd(dev, ref_qpi[dev] ? 8'hF5 : 8'h35);
            adr  = 24'($urandom);
            n    = $urandom_range(1, 4);
            data = $urandom;
            wop  = (ref_qpi[dev] || $urandom_range(0, 1) == 1) ? 8'h38 : 8'h02;
            rop  = (ref_qpi[dev] || $urandom_range(0, 1) == 1) ? 8'hEB : 8'h03;
            host_write(dev, wop, adr, data, n);
            host_read(dev, rop, adr, n, "rnd", 1'b0);
            check_eq("rnd_qpi", {29'h0, bus.qpi_mode}, {29'h0, ref_qpi});
        end

        // 6: reset during quad read data phase; memory survives
        if (!ref_qpi[1]) host_cmd(1, 8'h35);
        host_write(1, 8'h38, 24'h000100, 32'h0000_5AC3, 2);
        host_read(1, 8'hEB, 24'h000100, 2, "rst_mid", 1'b1);
        host_read(1, 8'h03, 24'h000100, 2, "post_rst", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
